// File: rtl/regfile_axil_port_if.sv
// AXI4-Lite slave bundle carrying the five channels of regfile_axil_port.
interface regfile_axil_port_if #(parameter int ADDR_W = 7);
  logic [ADDR_W-1:0] s_awaddr;
  logic              s_awvalid;
  logic              s_awready;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wstrb;
  logic              s_wvalid;
  logic              s_wready;
  logic [1:0]        s_bresp;
  logic              s_bvalid;
  logic              s_bready;
  logic [ADDR_W-1:0] s_araddr;
  logic              s_arvalid;
  logic              s_arready;
  logic [31:0]       s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rvalid;
  logic              s_rready;

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid,
           s_arready, s_rdata, s_rresp, s_rvalid
  );

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid,
           s_arready, s_rdata, s_rresp, s_rvalid
  );
endinterface

// File: rtl/regfile_axil_port.sv
// AXI4-Lite slave that exposes the 32 x 32-bit register file (x0..x31) as a
// word-addressed window; write and read channels run independently.
module regfile_axil_port #(
  parameter int ADDR_W = 7
) (
  input  logic                clk,
  input  logic                rst,
  regfile_axil_port_if.slave  s,
  output logic                RegWrite,
  output logic [4:0]          rd_addr,
  output logic [31:0]         write_data,
  output logic [4:0]          rs1_addr,
  input  logic [31:0]         rs1_data
);

  localparam logic [1:0] W_IDLE   = 2'd0;
  localparam logic [1:0] W_COMMIT = 2'd1;
  localparam logic [1:0] W_RESP   = 2'd2;

  localparam logic [1:0] R_IDLE   = 2'd0;
  localparam logic [1:0] R_FETCH  = 2'd1;
  localparam logic [1:0] R_VALID  = 2'd2;

  // Any address bit above [6] lies outside the 32-word window.
  localparam logic [ADDR_W-1:0] HI_MASK = ~ADDR_W'(7'h7F);

  logic [1:0]        w_state;
  logic              aw_held;
  logic              w_held;
  logic [ADDR_W-1:0] aw_addr;
  logic [31:0]       w_data;
  logic [3:0]        w_strb;
  logic [1:0]        bresp_q;
  logic              aw_hs;
  logic              w_hs;
  logic              w_err;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] ar_addr;
  logic [31:0]       rdata_q;
  logic [1:0]        rresp_q;
  logic              r_err;

  assign s.s_awready = !rst && (w_state == W_IDLE) && !aw_held;
  assign s.s_wready  = !rst && (w_state == W_IDLE) && !w_held;
  assign s.s_bvalid  = (w_state == W_RESP);
  assign s.s_bresp   = bresp_q;

  assign aw_hs = s.s_awvalid && s.s_awready;
  assign w_hs  = s.s_wvalid && s.s_wready;

  assign w_err = (aw_addr[1:0] != 2'b00) || (w_strb != 4'hF) ||
                 ((aw_addr & HI_MASK) != '0);

  assign rd_addr    = aw_addr[6:2];
  assign write_data = w_data;
  // Gated by rst so a reset landing on the commit cycle never reaches the file.
  assign RegWrite   = !rst && (w_state == W_COMMIT) && !w_err && (aw_addr[6:2] != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      bresp_q <= 2'b00;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_addr <= s.s_awaddr;
            aw_held <= 1'b1;
          end
          if (w_hs) begin
            w_data <= s.s_wdata;
            w_strb <= s.s_wstrb;
            w_held <= 1'b1;
          end
          if ((aw_held || aw_hs) && (w_held || w_hs)) w_state <= W_COMMIT;
        end
        W_COMMIT: begin
          bresp_q <= w_err ? 2'b10 : 2'b00;
          aw_held <= 1'b0;
          w_held  <= 1'b0;
          w_state <= W_RESP;
        end
        W_RESP: begin
          if (s.s_bready) w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign s.s_arready = !rst && (r_state == R_IDLE);
  assign s.s_rvalid  = (r_state == R_VALID);
  assign s.s_rdata   = rdata_q;
  assign s.s_rresp   = rresp_q;

  assign r_err = (ar_addr[1:0] != 2'b00) || ((ar_addr & HI_MASK) != '0);

  // rs1_data is sampled at the end of R_FETCH, so a same-edge write is not seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= R_IDLE;
      ar_addr  <= '0;
      rs1_addr <= 5'd0;
      rdata_q  <= '0;
      rresp_q  <= 2'b00;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s.s_arvalid) begin
            ar_addr  <= s.s_araddr;
            rs1_addr <= s.s_araddr[6:2];
            r_state  <= R_FETCH;
          end
        end
        R_FETCH: begin
          rdata_q <= (r_err || (rs1_addr == 5'd0)) ? 32'd0 : rs1_data;
          rresp_q <= r_err ? 2'b10 : 2'b00;
          r_state <= R_VALID;
        end
        R_VALID: begin
          if (s.s_rready) r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_axil_port.sv
// Bench for regfile_axil_port: a behavioural register file plus a shadow model
// feeding write/read expectation queues that each scenario task drains.
module tb_regfile_axil_port;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_axil_port_if #(.ADDR_W(AW)) bus();

  logic        RegWrite;
  logic [4:0]  rd_addr;
  logic [31:0] write_data;
  logic [4:0]  rs1_addr;
  logic [31:0] rs1_data;

  regfile_axil_port #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .s          (bus),
    .RegWrite   (RegWrite),
    .rd_addr    (rd_addr),
    .write_data (write_data),
    .rs1_addr   (rs1_addr),
    .rs1_data   (rs1_data)
  );

  logic [31:0] regs [32];
  always @(posedge clk) begin
    if (rst) for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (RegWrite) regs[rd_addr] <= write_data;
  end
  assign rs1_data = regs[rs1_addr];

  typedef struct { bit commit; logic [4:0] idx; logic [31:0] data; logic [1:0] resp; } wexp_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; } rexp_t;

  wexp_t       wq [$];
  rexp_t       rq [$];
  logic [31:0] shadow [32];
  int          checks   = 0;
  int          failures = 0;

  function automatic void push_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] st);
    wexp_t e;
    bit    err;
    err      = (a[1:0] != 2'b00) || (st != 4'hF) || (a[AW-1:7] != '0);
    e.idx    = a[6:2];
    e.data   = d;
    e.resp   = err ? 2'b10 : 2'b00;
    e.commit = !err && (a[6:2] != 5'd0);
    wq.push_back(e);
    if (e.commit) shadow[e.idx] = d;
  endfunction

  function automatic void push_read(input logic [AW-1:0] a);
    rexp_t e;
    bit    err;
    err    = (a[1:0] != 2'b00) || (a[AW-1:7] != '0);
    e.resp = err ? 2'b10 : 2'b00;
    e.data = (err || (a[6:2] == 5'd0)) ? 32'd0 : shadow[a[6:2]];
    rq.push_back(e);
  endfunction

  // Drives one write and/or one read concurrently and records what the DUT did;
  // cycle offsets are relative to the last AW/W handshake and the AR handshake.
  task automatic axi_txn(
    input  bit do_w, input logic [AW-1:0] waddr, input logic [31:0] wdata, input logic [3:0] wstrb,
    input  int aw_dly, input int w_dly,
    input  bit do_r, input logic [AW-1:0] raddr, input int r_stall,
    output int rw_count, output logic [31:0] rw_data, output logic [4:0] rw_idx, output int rw_rel,
    output logic [1:0] bresp, output int b_rel,
    output logic [31:0] rdata, output logic [1:0] rresp, output bit rstable, output int rv_rel,
    output bit timeout);
    bit aw_done, w_done, w_fin, ar_done, r_fin, aw_hs, w_hs, ar_hs, r_hs, b_hs;
    int hs_cyc, ar_cyc, rw_cyc, b_cyc, rv_cyc, nv;
    aw_done = !do_w; w_done = !do_w; w_fin = !do_w; ar_done = !do_r; r_fin = !do_r;
    hs_cyc = -1; ar_cyc = -1; rw_cyc = -100; b_cyc = -100; rv_cyc = -100; nv = 0;
    rw_count = 0; rw_idx = '0; rw_data = '0; bresp = '0; rdata = '0; rresp = '0;
    rstable = 1'b1; timeout = 1'b1;
    bus.s_awaddr = waddr; bus.s_wdata = wdata; bus.s_wstrb = wstrb; bus.s_araddr = raddr;
    for (int cyc = 0; cyc < 64; cyc++) begin
      bus.s_awvalid = do_w && !aw_done && (cyc >= aw_dly);
      bus.s_wvalid  = do_w && !w_done && (cyc >= w_dly);
      bus.s_arvalid = do_r && !ar_done;
      bus.s_bready  = 1'b1;
      bus.s_rready  = 1'b0;
      if (RegWrite) begin
        rw_count++; rw_idx = rd_addr; rw_data = write_data; rw_cyc = cyc;
      end
      if (bus.s_bvalid && !w_fin) begin
        bresp = bus.s_bresp; b_cyc = cyc;
      end
      if (bus.s_rvalid && !r_fin) begin
        if (nv == 0) begin
          rdata = bus.s_rdata; rresp = bus.s_rresp; rv_cyc = cyc;
        end else if (bus.s_rdata !== rdata || bus.s_rresp !== rresp) rstable = 1'b0;
        nv++;
        bus.s_rready = (nv > r_stall);
      end
      aw_hs = bus.s_awvalid && bus.s_awready;
      w_hs  = bus.s_wvalid && bus.s_wready;
      ar_hs = bus.s_arvalid && bus.s_arready;
      r_hs  = bus.s_rvalid && bus.s_rready;
      b_hs  = bus.s_bvalid && !w_fin;
      @(posedge clk); #1;
      if (aw_hs) aw_done = 1'b1;
      if (w_hs) w_done = 1'b1;
      if (do_w && aw_done && w_done && hs_cyc < 0) hs_cyc = cyc;
      if (ar_hs) begin ar_done = 1'b1; ar_cyc = cyc; end
      if (b_hs) w_fin = 1'b1;
      if (r_hs) r_fin = 1'b1;
      if (w_fin && r_fin) begin timeout = 1'b0; break; end
    end
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_arvalid = 1'b0;
    bus.s_bready = 1'b0; bus.s_rready = 1'b0;
    rw_rel = rw_cyc - hs_cyc;
    b_rel  = b_cyc - hs_cyc;
    rv_rel = rv_cyc - ar_cyc;
  endtask

  int          rw_count, rw_rel, b_rel, rv_rel;
  logic [31:0] rw_data, rdata;
  logic [4:0]  rw_idx;
  logic [1:0]  bresp, rresp;
  bit          rstable, tmo;
  wexp_t       we;
  rexp_t       re;

  task automatic test_reset();
    for (int i = 0; i < 32; i++) shadow[i] = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.s_awready, bus.s_wready, bus.s_arready} !== 3'b000) begin
      failures++; $display("[TB] FAIL reset_readies got=%b exp=000", {bus.s_awready, bus.s_wready, bus.s_arready});
    end
    checks++;
    if ({RegWrite, bus.s_bvalid, bus.s_rvalid} !== 3'b000) begin
      failures++; $display("[TB] FAIL reset_valids got=%b exp=000", {RegWrite, bus.s_bvalid, bus.s_rvalid});
    end
    checks++;
    if ({bus.s_bresp, bus.s_rresp, bus.s_rdata} !== 36'd0) begin
      failures++; $display("[TB] FAIL reset_resp_data got=%h exp=0", {bus.s_bresp, bus.s_rresp, bus.s_rdata});
    end
    checks++;
    if ({rs1_addr, rd_addr, write_data} !== 42'd0) begin
      failures++; $display("[TB] FAIL reset_rf_ports got=%h exp=0", {rs1_addr, rd_addr, write_data});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus.s_awready, bus.s_wready, bus.s_arready} !== 3'b111) begin
      failures++; $display("[TB] FAIL post_reset_readies got=%b exp=111", {bus.s_awready, bus.s_wready, bus.s_arready});
    end
  endtask

  task automatic test_write_same_cycle();
    push_write(8'h14, 32'hDEADBEEF, 4'hF);
    axi_txn(1, 8'h14, 32'hDEADBEEF, 4'hF, 0, 0, 0, '0, 0,
            rw_count, rw_data, rw_idx, rw_rel, bresp, b_rel, rdata, rresp, rstable, rv_rel, tmo);
    we = wq.pop_front();
    checks++;
    if (tmo !== 1'b0) begin failures++; $display("[TB] FAIL wr_same timeout got=%b exp=0", tmo); end
    checks++;
    if (rw_count !== 1) begin failures++; $display("[TB] FAIL wr_same regwrite_count got=%0d exp=1", rw_count); end
    checks++;
    if (rw_idx !== we.idx || rw_data !== we.data) begin
      failures++; $display("[TB] FAIL wr_same idx/data got=%0d/%h exp=%0d/%h", rw_idx, rw_data, we.idx, we.data);
    end
    checks++;
    if (rw_rel !== 1) begin failures++; $display("[TB] FAIL wr_same regwrite_latency got=%0d exp=1", rw_rel); end
    checks++;
    if (b_rel !== 2 || bresp !== we.resp) begin
      failures++; $display("[TB] FAIL wr_same bvalid_lat/bresp got=%0d/%b exp=2/%b", b_rel, bresp, we.resp);
    end
  endtask

  task automatic test_write_x0();
    push_write(8'h00, 32'h1234, 4'hF);
    axi_txn(1, 8'h00, 32'h1234, 4'hF, 2, 0, 0, '0, 0,
            rw_count, rw_data, rw_idx, rw_rel, bresp, b_rel, rdata, rresp, rstable, rv_rel, tmo);
    we = wq.pop_front();
    checks++;
    if (tmo !== 1'b0 || rw_count !== 0) begin
      failures++; $display("[TB] FAIL wr_x0 timeout/regwrite_count got=%b/%0d exp=0/0", tmo, rw_count);
    end
    checks++;
    if (bresp !== we.resp) begin failures++; $display("[TB] FAIL wr_x0 bresp got=%b exp=%b", bresp, we.resp); end
  endtask

  task automatic test_read_stall();
    push_read(8'h14);
    axi_txn(0, '0, '0, '0, 0, 0, 1, 8'h14, 3,
            rw_count, rw_data, rw_idx, rw_rel, bresp, b_rel, rdata, rresp, rstable, rv_rel, tmo);
    re = rq.pop_front();
    checks++;
    if (tmo !== 1'b0) begin failures++; $display("[TB] FAIL rd_stall timeout got=%b exp=0", tmo); end
    checks++;
    if (rdata !== re.data || rresp !== re.resp) begin
      failures++; $display("[TB] FAIL rd_stall data/resp got=%h/%b exp=%h/%b", rdata, rresp, re.data, re.resp);
    end
    checks++;
    if (rstable !== 1'b1) begin failures++; $display("[TB] FAIL rd_stall stable got=%b exp=1", rstable); end
    checks++;
    if (rv_rel !== 2) begin failures++; $display("[TB] FAIL rd_stall rvalid_latency got=%0d exp=2", rv_rel); end
  endtask

  task automatic test_errors();
    logic [AW-1:0] ea [3];
    logic [3:0]    es [3];
    ea[0] = 8'h16; es[0] = 4'hF;
    ea[1] = 8'h18; es[1] = 4'h3;
    ea[2] = 8'h94; es[2] = 4'hF;
    for (int i = 0; i < 3; i++) begin
      push_write(ea[i], 32'hBAD0_0000 + i, es[i]);
      axi_txn(1, ea[i], 32'hBAD0_0000 + i, es[i], i, 0, 0, '0, 0,
              rw_count, rw_data, rw_idx, rw_rel, bresp, b_rel, rdata, rresp, rstable, rv_rel, tmo);
      we = wq.pop_front();
      checks++;
      if (tmo !== 1'b0 || rw_count !== (we.commit ? 1 : 0) || bresp !== we.resp) begin
        failures++; $display("[TB] FAIL wr_err%0d tmo/regwrite/bresp got=%b/%0d/%b exp=0/%0d/%b",
                             i, tmo, rw_count, bresp, we.commit ? 1 : 0, we.resp);
      end
    end
    push_read(8'h81);
    axi_txn(0, '0, '0, '0, 0, 0, 1, 8'h81, 0,
            rw_count, rw_data, rw_idx, rw_rel, bresp, b_rel, rdata, rresp, rstable, rv_rel, tmo);
    re = rq.pop_front();
    checks++;
    if (tmo !== 1'b0 || rdata !== re.data || rresp !== re.resp) begin
      failures++; $display("[TB] FAIL rd_err tmo/data/resp got=%b/%h/%b exp=0/%h/%b", tmo, rdata, rresp, re.data, re.resp);
    end
  endtask

  task automatic test_collision();
    push_write(8'h1C, 32'h11, 4'hF);
    axi_txn(1, 8'h1C, 32'h11, 4'hF, 0, 0, 0, '0, 0,
            rw_count, rw_data, rw_idx, rw_rel, bresp, b_rel, rdata, rresp, rstable, rv_rel, tmo);
    we = wq.pop_front();
    checks++;
    if (tmo !== 1'b0 || bresp !== we.resp) begin
      failures++; $display("[TB] FAIL coll_setup tmo/bresp got=%b/%b exp=0/%b", tmo, bresp, we.resp);
    end
    // Read expectation is taken before the write updates the shadow.
    push_read(8'h1C);
    push_write(8'h1C, 32'hA5A5A5A5, 4'hF);
    axi_txn(1, 8'h1C, 32'hA5A5A5A5, 4'hF, 0, 0, 1, 8'h1C, 0,
            rw_count, rw_data, rw_idx, rw_rel, bresp, b_rel, rdata, rresp, rstable, rv_rel, tmo);
    we = wq.pop_front();
    re = rq.pop_front();
    checks++;
    if (tmo !== 1'b0 || rw_count !== 1 || bresp !== we.resp) begin
      failures++; $display("[TB] FAIL coll_write tmo/regwrite/bresp got=%b/%0d/%b exp=0/1/%b", tmo, rw_count, bresp, we.resp);
    end
    checks++;
    if (rdata !== re.data) begin failures++; $display("[TB] FAIL coll_read_old got=%h exp=%h", rdata, re.data); end
    push_read(8'h1C);
    axi_txn(0, '0, '0, '0, 0, 0, 1, 8'h1C, 1,
            rw_count, rw_data, rw_idx, rw_rel, bresp, b_rel, rdata, rresp, rstable, rv_rel, tmo);
    re = rq.pop_front();
    checks++;
    if (tmo !== 1'b0 || rdata !== re.data) begin
      failures++; $display("[TB] FAIL coll_read_new tmo/data got=%b/%h exp=0/%h", tmo, rdata, re.data);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a;
    logic [31:0]   d;
    for (int i = 0; i < 10; i++) begin
      a = '0;
      a[6:2] = 5'($urandom_range(0, 31));
      if (i == 4) a[0] = 1'b1;
      d = $urandom;
      push_write(a, d, 4'hF);
      axi_txn(1, a, d, 4'hF, $urandom_range(0, 3), $urandom_range(0, 3), 0, '0, 0,
              rw_count, rw_data, rw_idx, rw_rel, bresp, b_rel, rdata, rresp, rstable, rv_rel, tmo);
      we = wq.pop_front();
      checks++;
      if (tmo !== 1'b0 || bresp !== we.resp || rw_count !== (we.commit ? 1 : 0) ||
          (we.commit && (rw_data !== we.data || rw_idx !== we.idx))) begin
        failures++; $display("[TB] FAIL b2b_wr%0d tmo/bresp/cnt/data got=%b/%b/%0d/%h exp=0/%b/%0d/%h",
                             i, tmo, bresp, rw_count, rw_data, we.resp, we.commit ? 1 : 0, we.data);
      end
      a[1:0] = 2'b00;
      push_read(a);
      axi_txn(0, '0, '0, '0, 0, 0, 1, a, $urandom_range(0, 2),
              rw_count, rw_data, rw_idx, rw_rel, bresp, b_rel, rdata, rresp, rstable, rv_rel, tmo);
      re = rq.pop_front();
      checks++;
      if (tmo !== 1'b0 || rdata !== re.data || rresp !== re.resp || rw_count !== 0) begin
        failures++; $display("[TB] FAIL b2b_rd%0d tmo/data/resp/cnt got=%b/%h/%b/%0d exp=0/%h/%b/0",
                             i, tmo, rdata, rresp, rw_count, re.data, re.resp);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit bad;
    bad = 1'b0;
    bus.s_awaddr = 8'h20; bus.s_awvalid = 1'b1;
    bus.s_araddr = 8'h20; bus.s_arvalid = 1'b1;
    @(posedge clk); #1;
    bus.s_awvalid = 1'b0; bus.s_arvalid = 1'b0;
    bus.s_wdata = 32'hCAFEF00D; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
    rst = 1'b1;
    if (RegWrite) bad = 1'b1;
    @(posedge clk); #1;
    bus.s_wvalid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) shadow[i] = '0;
    bus.s_bready = 1'b1; bus.s_rready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (RegWrite || bus.s_bvalid || bus.s_rvalid) bad = 1'b1;
      @(posedge clk); #1;
      if (c == 0) begin
        checks++;
        if ({bus.s_awready, bus.s_wready, bus.s_arready} !== 3'b111) begin
          failures++; $display("[TB] FAIL rst_mid_readies got=%b exp=111", {bus.s_awready, bus.s_wready, bus.s_arready});
        end
      end
    end
    bus.s_bready = 1'b0; bus.s_rready = 1'b0;
    checks++;
    if (bad !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_abort got=%b exp=0", bad); end
    push_write(8'h24, 32'h600D600D, 4'hF);
    axi_txn(1, 8'h24, 32'h600D600D, 4'hF, 3, 0, 0, '0, 0,
            rw_count, rw_data, rw_idx, rw_rel, bresp, b_rel, rdata, rresp, rstable, rv_rel, tmo);
    we = wq.pop_front();
    checks++;
    if (tmo !== 1'b0 || rw_count !== 1 || rw_rel !== 1 || rw_idx !== we.idx || bresp !== we.resp) begin
      failures++; $display("[TB] FAIL rst_mid_next_wr tmo/cnt/lat/idx/bresp got=%b/%0d/%0d/%0d/%b exp=0/1/1/%0d/%b",
                           tmo, rw_count, rw_rel, rw_idx, bresp, we.idx, we.resp);
    end
    push_read(8'h20);
    axi_txn(0, '0, '0, '0, 0, 0, 1, 8'h20, 0,
            rw_count, rw_data, rw_idx, rw_rel, bresp, b_rel, rdata, rresp, rstable, rv_rel, tmo);
    re = rq.pop_front();
    checks++;
    if (tmo !== 1'b0 || rdata !== re.data) begin
      failures++; $display("[TB] FAIL rst_mid_x8 tmo/data got=%b/%h exp=0/%h", tmo, rdata, re.data);
    end
  endtask

  initial begin
    bus.s_awaddr = '0; bus.s_awvalid = 1'b0;
    bus.s_wdata = '0; bus.s_wstrb = '0; bus.s_wvalid = 1'b0;
    bus.s_bready = 1'b0;
    bus.s_araddr = '0; bus.s_arvalid = 1'b0;
    bus.s_rready = 1'b0;
    test_reset();
    test_write_same_cycle();
    test_write_x0();
    test_read_stall();
    test_errors();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
